// File: rtl/vector_conv_stream.sv
// Streaming 1-D convolution of a multi-channel pixel vector with one shared signed kernel.
// Three-stage valid/ready pipeline; define VECTOR_CONV_ROUND_EN for round-half-up before the shift.
module vector_conv_stream #(
  parameter int LENGTH       = 10,
  parameter int COV_SIZE     = 3,
  parameter int CH_WIDTH     = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int CHANNELS     = 3,
  parameter int SHIFT        = 0
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               in_valid,
  output logic                                               in_ready,
  input  logic [CHANNELS*LENGTH*CH_WIDTH-1:0]                pixel_vector,
  input  logic [COV_SIZE*WEIGHT_WIDTH-1:0]                   weight_vector,
  output logic                                               out_valid,
  input  logic                                               out_ready,
  output logic [CHANNELS*(LENGTH-COV_SIZE+1)*CH_WIDTH-1:0]   out_vector,
  output logic                                               sat_flag
);

  localparam int OUT_LEN = LENGTH - COV_SIZE + 1;
  localparam int PIX_W   = CHANNELS * LENGTH * CH_WIDTH;
  localparam int WV_W    = COV_SIZE * WEIGHT_WIDTH;
  localparam int OUT_W   = CHANNELS * OUT_LEN * CH_WIDTH;
  localparam int PROD_W  = CH_WIDTH + WEIGHT_WIDTH + 1;
  localparam int SUM_W   = PROD_W + $clog2(COV_SIZE);
  localparam logic signed [SUM_W:0] MAX_PIX = (SUM_W+1)'((1 << CH_WIDTH) - 1);
`ifdef VECTOR_CONV_ROUND_EN
  localparam int RND_BIAS = (SHIFT > 0) ? (1 << ((SHIFT > 0) ? SHIFT - 1 : 0)) : 0;
`endif

  logic                     adv;
  logic                     vld_p0, vld_p1, vld_p2;
  logic [PIX_W-1:0]         pix_p0;
  logic [WV_W-1:0]          w_p0;
  logic signed [PROD_W-1:0] prod_p1 [CHANNELS][OUT_LEN][COV_SIZE];
  logic [OUT_W-1:0]         out_nxt;
  logic                     sat_nxt;

  // One extra bit of headroom so the rounding bias can never wrap the sum.
  function automatic logic signed [SUM_W:0] round_shift(input logic signed [SUM_W-1:0] sum);
    logic signed [SUM_W:0] ext;
    ext = {sum[SUM_W-1], sum};
`ifdef VECTOR_CONV_ROUND_EN
    ext = ext + (SUM_W+1)'(RND_BIAS);
`endif
    return ext >>> SHIFT;
  endfunction

  // MSB of the result flags a clamp event.
  function automatic logic [CH_WIDTH:0] clamp(input logic signed [SUM_W:0] v);
    if (v < 0)
      return {1'b1, {CH_WIDTH{1'b0}}};
    else if (v > MAX_PIX)
      return {1'b1, {CH_WIDTH{1'b1}}};
    return {1'b0, v[CH_WIDTH-1:0]};
  endfunction

  // Reset forces the pipeline open so the block reports ready while being cleared.
  assign adv       = rst | ~vld_p2 | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
      out_vector <= '0;
      sat_flag   <= 1'b0;
    end else if (adv) begin
      vld_p0 <= in_valid;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        out_vector <= out_nxt;
        sat_flag   <= sat_nxt;
      end
    end
  end

  // Stage p0: capture pixels with their own weights; stage p1: all tap products
  always_ff @(posedge clk) begin
    if (adv) begin
      pix_p0 <= pixel_vector;
      w_p0   <= weight_vector;
      for (int c = 0; c < CHANNELS; c++)
        for (int i = 0; i < OUT_LEN; i++)
          for (int j = 0; j < COV_SIZE; j++)
            prod_p1[c][i][j] <=
              PROD_W'($signed({1'b0, pix_p0[(c*LENGTH+i+j)*CH_WIDTH +: CH_WIDTH]})) *
              PROD_W'($signed(w_p0[j*WEIGHT_WIDTH +: WEIGHT_WIDTH]));
    end
  end

  // Stage p2: tap sum, shift, clamp
  always_comb begin
    logic signed [SUM_W-1:0] acc;
    logic [CH_WIDTH:0]       q;
    out_nxt = '0;
    sat_nxt = 1'b0;
    acc     = '0;
    q       = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      for (int i = 0; i < OUT_LEN; i++) begin
        acc = '0;
        for (int j = 0; j < COV_SIZE; j++)
          acc = acc + SUM_W'(prod_p1[c][i][j]);
        q = clamp(round_shift(acc));
        out_nxt[(c*OUT_LEN+i)*CH_WIDTH +: CH_WIDTH] = q[CH_WIDTH-1:0];
        sat_nxt = sat_nxt | q[CH_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_vector_conv_stream.sv
// Bench for vector_conv_stream: scoreboard model plus directed vectors on three configurations.
module tb_vector_conv_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // default configuration
  logic         in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, sat_flag;
  logic [239:0] pixel_vector = '0;
  logic [23:0]  weight_vector = '0;
  logic [191:0] out_vector;

  // SHIFT=2 configuration
  logic         sh_in_valid = 1'b0, sh_in_ready, sh_out_valid, sh_sat;
  logic [239:0] sh_pix = '0;
  logic [23:0]  sh_w = '0;
  logic [191:0] sh_out;

  // single channel, kernel as long as the vector
  logic         one_in_valid = 1'b0, one_in_ready, one_out_valid, one_sat;
  logic [39:0]  one_pix = '0;
  logic [39:0]  one_w = '0;
  logic [7:0]   one_out;

  int checks = 0;
  int errors = 0;
  int n_out  = 0;

  logic [191:0] exp_q[$];
  bit           sat_q[$];

  vector_conv_stream u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pixel_vector(pixel_vector), .weight_vector(weight_vector),
    .out_valid(out_valid), .out_ready(out_ready), .out_vector(out_vector), .sat_flag(sat_flag)
  );

  vector_conv_stream #(.SHIFT(2)) u_sh (
    .clk(clk), .rst(rst), .in_valid(sh_in_valid), .in_ready(sh_in_ready),
    .pixel_vector(sh_pix), .weight_vector(sh_w),
    .out_valid(sh_out_valid), .out_ready(1'b1), .out_vector(sh_out), .sat_flag(sh_sat)
  );

  vector_conv_stream #(.LENGTH(5), .COV_SIZE(5), .CHANNELS(1)) u_one (
    .clk(clk), .rst(rst), .in_valid(one_in_valid), .in_ready(one_in_ready),
    .pixel_vector(one_pix), .weight_vector(one_w),
    .out_valid(one_out_valid), .out_ready(1'b1), .out_vector(one_out), .sat_flag(one_sat)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Direct evaluation of the convolution definition on the default configuration.
  function automatic void model(input logic [239:0] p, input logic [23:0] w,
                                output logic [191:0] o, output bit s);
    int acc;
    o = '0;
    s = 1'b0;
    for (int c = 0; c < 3; c++)
      for (int i = 0; i < 8; i++) begin
        acc = 0;
        for (int j = 0; j < 3; j++)
          acc += int'(p[(c*10+i+j)*8 +: 8]) * int'($signed(w[j*8 +: 8]));
        if (acc < 0) begin
          o[(c*8+i)*8 +: 8] = 8'd0;
          s = 1'b1;
        end else if (acc > 255) begin
          o[(c*8+i)*8 +: 8] = 8'd255;
          s = 1'b1;
        end else begin
          o[(c*8+i)*8 +: 8] = acc[7:0];
        end
      end
  endfunction

  function automatic logic [239:0] mkpix(input int n);
    logic [239:0] v;
    v = '0;
    for (int c = 0; c < 3; c++)
      for (int k = 0; k < 10; k++)
        v[(c*10+k)*8 +: 8] = 8'((n*37 + c*11 + k*23 + 5) % 256);
    return v;
  endfunction

  function automatic logic [23:0] mkw(input int n);
    logic [23:0] w;
    w[7:0]   = 8'(n - 2);
    w[15:8]  = 8'd3;
    w[23:16] = 8'hFF;
    return w;
  endfunction

  // scoreboard: accepted inputs in, transferred outputs out
  always @(posedge clk) begin
    logic [191:0] o;
    bit s;
    if (rst) begin
      exp_q.delete();
      sat_q.delete();
    end else begin
      if (out_valid && out_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        void'(sat_q.pop_front());
        n_out++;
      end
      if (in_valid && in_ready) begin
        model(pixel_vector, weight_vector, o, s);
        exp_q.push_back(o);
        sat_q.push_back(s);
      end
    end
  end

  // compare process
  logic [191:0] prev_vec;
  bit           prev_stall = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      chk("in_ready_in_reset", 256'(in_ready), 256'(1));
      prev_stall = 1'b0;
    end else begin
      chk("in_ready_rule", 256'(in_ready), 256'(!out_valid || out_ready));
      if (prev_stall) begin
        chk("stall_vector_hold", 256'(out_vector), 256'(prev_vec));
        chk("stall_valid_hold", 256'(out_valid), 256'(1));
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", 256'(out_valid), 256'(0));
        end else begin
          chk("out_vector", 256'(out_vector), 256'(exp_q[0]));
          chk("sat_flag", 256'(sat_flag), 256'(sat_q[0]));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_vec   = out_vector;
    end
  end

  task automatic send(input logic [239:0] p, input logic [23:0] w);
    bit ok;
    ok = 1'b0;
    pixel_vector  = p;
    weight_vector = w;
    in_valid      = 1'b1;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) begin
      chk("send_timeout", 256'(0), 256'(1));
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  // Accept one vector and pin the three-edge latency plus literal result.
  task automatic lat_test(input string name, input logic [239:0] p, input logic [23:0] w,
                          input logic [191:0] ev, input bit es);
    @(posedge clk);
    #1;
    pixel_vector  = p;
    weight_vector = w;
    in_valid      = 1'b1;
    @(negedge clk);
    chk({name, "_in_ready"}, 256'(in_ready), 256'(1));
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk({name, "_lat1"}, 256'(out_valid), 256'(0));
    @(posedge clk);
    @(negedge clk);
    chk({name, "_lat2"}, 256'(out_valid), 256'(0));
    @(posedge clk);
    @(negedge clk);
    chk({name, "_lat3"}, 256'(out_valid), 256'(1));
    chk({name, "_vec"}, 256'(out_vector), 256'(ev));
    chk({name, "_sat"}, 256'(sat_flag), 256'(es));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int t = 0; t < 60 && (exp_q.size() != 0 || out_valid); t++) @(posedge clk);
    #1;
    chk("drain_empty", 256'(exp_q.size()), 256'(0));
  endtask

  initial begin
    logic [191:0] mo;
    bit ms;
    int base;
    logic [7:0] sh_exp;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", 256'(out_valid), 256'(0));
    chk("reset_out_vector", 256'(out_vector), 256'(0));
    chk("reset_sat_flag", 256'(sat_flag), 256'(0));
    @(posedge clk);
    #1 rst = 1'b0;

    // model pins
    model({30{8'd10}}, {8'd1, 8'd2, 8'd1}, mo, ms);
    chk("model_pin_40", 256'({ms, mo}), 256'({1'b0, {24{8'd40}}}));
    model({30{8'd200}}, {8'd1, 8'd1, 8'd1}, mo, ms);
    chk("model_pin_255", 256'({ms, mo}), 256'({1'b1, {24{8'd255}}}));

    lat_test("ones121", {30{8'd10}}, {8'd1, 8'd2, 8'd1}, {24{8'd40}}, 1'b0);
    lat_test("sat_hi", {30{8'd200}}, {8'd1, 8'd1, 8'd1}, {24{8'd255}}, 1'b1);
    lat_test("sat_lo", {30{8'd200}}, {8'd0, 8'd0, 8'hFF}, {24{8'd0}}, 1'b1);
    drain();

    // burst of five with a downstream stall in the middle
    base = n_out;
    fork
      begin
        for (int n = 0; n < 5; n++) send(mkpix(n), mkw(n));
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("burst_count", 256'(n_out - base), 256'(5));

    // reset with two vectors in flight
    base = n_out;
    send({30{8'd10}}, {8'd1, 8'd2, 8'd1});
    send({30{8'd20}}, {8'd1, 8'd1, 8'd1});
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      chk("flushed_no_valid", 256'(out_valid), 256'(0));
    end
    chk("flushed_count", 256'(n_out - base), 256'(0));
    lat_test("after_rst", {30{8'd10}}, {8'd1, 8'd2, 8'd1}, {24{8'd40}}, 1'b0);
    drain();

    // SHIFT=2 and single-output configurations
`ifdef VECTOR_CONV_ROUND_EN
    sh_exp = 8'd2;
`else
    sh_exp = 8'd1;
`endif
    sh_pix = {30{8'd2}};
    sh_w   = {3{8'd1}};
    for (int k = 0; k < 5; k++) one_pix[k*8 +: 8] = 8'(k + 1);
    one_w = {5{8'd1}};
    sh_in_valid  = 1'b1;
    one_in_valid = 1'b1;
    @(posedge clk);
    #1;
    sh_in_valid  = 1'b0;
    one_in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("shift_valid", 256'(sh_out_valid), 256'(1));
    chk("shift_vec", 256'(sh_out), 256'({24{sh_exp}}));
    chk("shift_sat", 256'(sh_sat), 256'(0));
    chk("single_valid", 256'(one_out_valid), 256'(1));
    chk("single_out", 256'(one_out), 256'(8'd15));
    chk("single_sat", 256'(one_sat), 256'(0));

    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
